// File: rtl/conv_address_sequencer.sv
// conv_address_sequencer
// Address generator for a 2-D convolution over an IMAGE_WIDTH x IMAGE_HEIGHT
// image. It feeds NUM_UNITS parallel MAC units. Each unit owns one output
// pixel per batch. Every tap of the k x k kernel is issued once per batch with
// a valid/ready handshake.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   start             begin a pass (sampled only while idle)
//   kernel_dim        kernel side k, latched at start
//   stride_sel        0 = stride 1, 1 = stride 2, latched at start
//   pad_en            zero padding of 1, latched at start (padding build only)
//   tap_valid/ready   tap handshake with the MAC array
//   img_addr          per-unit image address, NUM_UNITS x AW packed
//   krn_addr          shared kernel tap address ky*k+kx
//   out_addr          per-unit output pixel index, NUM_UNITS x AW packed
//   active_units      unit holds a real output pixel in this batch
//   tap_zero          unit's tap falls in the padding border
//   tap_first/last    first / last tap of a batch
//   busy, done, error not idle / end-of-pass pulse / sticky bad configuration
//
// Build option: define CONV_SEQ_PADDING_EN to honour pad_en. Without the macro,
// pad_en is ignored and tap_zero is constant zero.
module conv_address_sequencer #(
  parameter int IMAGE_WIDTH  = 5,
  parameter int IMAGE_HEIGHT = 5,
  parameter int NUM_UNITS    = 9,
  parameter int MAX_KERNEL   = 5,
  localparam int AW = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
  localparam int KW = $clog2(MAX_KERNEL + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [KW-1:0]          kernel_dim,
  input  logic                   stride_sel,
  input  logic                   pad_en,
  output logic                   tap_valid,
  input  logic                   tap_ready,
  output logic [NUM_UNITS*AW-1:0] img_addr,
  output logic [AW-1:0]          krn_addr,
  output logic [NUM_UNITS*AW-1:0] out_addr,
  output logic [NUM_UNITS-1:0]   active_units,
  output logic [NUM_UNITS-1:0]   tap_zero,
  output logic                   tap_first,
  output logic                   tap_last,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  // Position counters can run past the last output row in the final batch.
  // They therefore get headroom beyond the image size.
  localparam int CW = $clog2(2 * (IMAGE_WIDTH + IMAGE_HEIGHT + NUM_UNITS + MAX_KERNEL) + 8) + 1;
  localparam int BW = $clog2((IMAGE_WIDTH + 2) * (IMAGE_HEIGHT + 2) + NUM_UNITS + 1) + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_BATCH, S_DONE} state_t;

  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d, kx_q, kx_d, ky_q, ky_d;
  logic          s_q, s_d, pad_q, pad_d, error_q, error_d;
  logic [AW-1:0] krn_q, krn_d;
  logic [BW-1:0] base_q, base_d;
  logic [CW-1:0] ox_q [NUM_UNITS];
  logic [CW-1:0] ox_d [NUM_UNITS];
  logic [CW-1:0] oy_q [NUM_UNITS];
  logic [CW-1:0] oy_d [NUM_UNITS];
  logic          pad_in;

`ifdef CONV_SEQ_PADDING_EN
  localparam bit HAS_PAD = 1'b1;
  assign pad_in = pad_en;
`else
  localparam bit HAS_PAD = 1'b0;
  logic unused_pad_en;
  assign unused_pad_en = pad_en;
  assign pad_in = 1'b0;
`endif

  // Output grid size and configuration legality from the latched setup.
  // A stride of 2 is a right shift, so no divider is needed.
  logic [CW-1:0] k_ext, w_span, h_span, ow_w, oh_w;
  logic          cfg_bad;
  always_comb begin
    k_ext   = CW'(k_q);
    w_span  = CW'(IMAGE_WIDTH) + (pad_q ? CW'(2) : CW'(0));
    h_span  = CW'(IMAGE_HEIGHT) + (pad_q ? CW'(2) : CW'(0));
    cfg_bad = (k_q == '0) || (int'(k_q) > MAX_KERNEL) || (k_ext > w_span) || (k_ext > h_span);
    ow_w    = ((w_span - k_ext) >> s_q) + CW'(1);
    oh_w    = ((h_span - k_ext) >> s_q) + CW'(1);
  end

  // Advance a raster position by one output pixel.
  function automatic logic [2*CW-1:0] step_pos(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                               input logic [CW-1:0] w);
    if (x + CW'(1) == w) return {y + CW'(1), CW'(0)};
    else                 return {y, x + CW'(1)};
  endfunction

  // Positions for the next batch form a chain of +1 steps. The chain starts
  // at (0,0) in LOAD. Otherwise it starts one step after the current last
  // unit. The next batch has work only if that first position is still
  // inside the output grid.
  logic [CW-1:0] nx [NUM_UNITS];
  logic [CW-1:0] ny [NUM_UNITS];
  logic [CW-1:0] sx, sy;
  logic          more_w;
  always_comb begin
    {sy, sx} = step_pos(ox_q[NUM_UNITS-1], oy_q[NUM_UNITS-1], ow_w);
    more_w   = (sy < oh_w);
    if (state_q == S_LOAD) begin
      nx[0] = '0;
      ny[0] = '0;
    end else begin
      nx[0] = sx;
      ny[0] = sy;
    end
    for (int u = 1; u < NUM_UNITS; u++) begin
      {ny[u], nx[u]} = step_pos(nx[u-1], ny[u-1], ow_w);
    end
  end

  logic fire, last_tap;
  assign fire     = (state_q == S_ISSUE) && tap_ready;
  assign last_tap = (kx_q == k_q - KW'(1)) && (ky_q == k_q - KW'(1));

  // State register and datapath flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      s_q     <= 1'b0;
      pad_q   <= 1'b0;
      error_q <= 1'b0;
      kx_q    <= '0;
      ky_q    <= '0;
      krn_q   <= '0;
      base_q  <= '0;
      ox_q    <= '{default: '0};
      oy_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      pad_q   <= pad_d;
      error_q <= error_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      krn_q   <= krn_d;
      base_q  <= base_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = cfg_bad ? S_DONE : S_ISSUE;
      S_ISSUE: if (fire && last_tap) state_d = more_w ? S_BATCH : S_DONE;
      S_BATCH: state_d = S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: configuration latch, tap walk, and batch advance.
  always_comb begin
    k_d     = k_q;
    s_d     = s_q;
    pad_d   = pad_q;
    error_d = error_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    krn_d   = krn_q;
    base_d  = base_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d     = kernel_dim;
          s_d     = stride_sel;
          pad_d   = pad_in;
          error_d = 1'b0;
        end
      end
      S_LOAD: begin
        kx_d   = '0;
        ky_d   = '0;
        krn_d  = '0;
        base_d = '0;
        ox_d   = nx;
        oy_d   = ny;
        if (cfg_bad) error_d = 1'b1;
      end
      S_ISSUE: begin
        if (fire) begin
          if (last_tap) begin
            kx_d  = '0;
            ky_d  = '0;
            krn_d = '0;
          end else begin
            krn_d = krn_q + AW'(1);
            if (kx_q == k_q - KW'(1)) begin
              kx_d = '0;
              ky_d = ky_q + KW'(1);
            end else begin
              kx_d = kx_q + KW'(1);
            end
          end
        end
      end
      S_BATCH: begin
        base_d = base_q + BW'(NUM_UNITS);
        ox_d   = nx;
        oy_d   = ny;
      end
      default: ;
    endcase
  end

  // Output decode. All tap outputs are zero outside ISSUE. Inactive units and
  // taps that fall in the padding report address 0.
  always_comb begin
    int row, col;
    row          = 0;
    col          = 0;
    tap_valid    = 1'b0;
    img_addr     = '0;
    out_addr     = '0;
    krn_addr     = '0;
    active_units = '0;
    tap_zero     = '0;
    tap_first    = 1'b0;
    tap_last     = 1'b0;
    if (state_q == S_ISSUE) begin
      tap_valid = 1'b1;
      krn_addr  = krn_q;
      tap_first = (kx_q == '0) && (ky_q == '0);
      tap_last  = last_tap;
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (oy_q[u] < oh_w) begin
          active_units[u]         = 1'b1;
          out_addr[u*AW +: AW]    = AW'(base_q + BW'(u));
          row = (int'(oy_q[u]) << s_q) + int'(ky_q) - int'(pad_q);
          col = (int'(ox_q[u]) << s_q) + int'(kx_q) - int'(pad_q);
          if (row < 0 || row >= IMAGE_HEIGHT || col < 0 || col >= IMAGE_WIDTH)
            tap_zero[u] = HAS_PAD;
          else
            img_addr[u*AW +: AW] = AW'(row * IMAGE_WIDTH + col);
        end
      end
    end
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_DONE);
    error = error_q;
  end

endmodule

// File: tb/tb_conv_address_sequencer.sv
// Testbench for conv_address_sequencer. It drives two instances (9 units and
// 4 units) with the same stimulus. Expected taps come from a reference model
// that uses plain division and modulo. They are queued when a pass starts and
// popped as the selected instance presents them.
module tb_conv_address_sequencer;

  localparam int IW = 5;
  localparam int IH = 5;
  localparam int AW = 5;
  localparam int KW = 3;
`ifdef CONV_SEQ_PADDING_EN
  localparam int PAD_BUILD = 1;
`else
  localparam int PAD_BUILD = 0;
`endif

  logic clk = 1'b0;
  logic reset, start, stride_sel, pad_en, tap_ready;
  logic [KW-1:0] kernel_dim;

  logic        tv9, first9, last9, busy9, done9, err9;
  logic [44:0] img9, out9;
  logic [4:0]  krn9;
  logic [8:0]  act9, tz9;

  logic        tv4, first4, last4, busy4, done4, err4;
  logic [19:0] img4, out4;
  logic [4:0]  krn4;
  logic [3:0]  act4, tz4;

  conv_address_sequencer dut9 (
    .clk(clk), .reset(reset), .start(start), .kernel_dim(kernel_dim),
    .stride_sel(stride_sel), .pad_en(pad_en), .tap_valid(tv9), .tap_ready(tap_ready),
    .img_addr(img9), .krn_addr(krn9), .out_addr(out9), .active_units(act9),
    .tap_zero(tz9), .tap_first(first9), .tap_last(last9), .busy(busy9),
    .done(done9), .error(err9));

  conv_address_sequencer #(.NUM_UNITS(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .kernel_dim(kernel_dim),
    .stride_sel(stride_sel), .pad_en(pad_en), .tap_valid(tv4), .tap_ready(tap_ready),
    .img_addr(img4), .krn_addr(krn4), .out_addr(out4), .active_units(act4),
    .tap_zero(tz4), .tap_first(first4), .tap_last(last4), .busy(busy4),
    .done(done4), .error(err4));

  always #5 clk = ~clk;

  typedef struct {
    logic [44:0] img;
    logic [4:0]  krn;
    logic [44:0] oa;
    logic [8:0]  act;
    logic [8:0]  tz;
    logic        first;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: queue every tap of the pass and report the batch count.
  task automatic push_expected(input int n, input int k, input int s, input int p, output int nb);
    int st, ow, oh, total, idx, row, col;
    st = s ? 2 : 1;
    ow = 0;
    while (ow * st + k <= IW + 2 * p) ow++;
    oh = 0;
    while (oh * st + k <= IH + 2 * p) oh++;
    total = ow * oh;
    nb = (total + n - 1) / n;
    for (int b = 0; b < nb; b++)
      for (int ky = 0; ky < k; ky++)
        for (int kx = 0; kx < k; kx++) begin
          exp_t e;
          e.img = '0; e.oa = '0; e.act = '0; e.tz = '0;
          e.krn   = 5'(ky * k + kx);
          e.first = (ky == 0 && kx == 0);
          e.last  = (ky == k - 1 && kx == k - 1);
          for (int u = 0; u < n; u++) begin
            idx = b * n + u;
            if (idx < total) begin
              e.act[u] = 1'b1;
              e.oa[u*AW +: AW] = 5'(idx);
              row = (idx / ow) * st + ky - p;
              col = (idx % ow) * st + kx - p;
              if (row < 0 || row >= IH || col < 0 || col >= IW) e.tz[u] = 1'b1;
              else e.img[u*AW +: AW] = 5'(row * IW + col);
            end
          end
          exp_q.push_back(e);
        end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy9 || busy4) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (busy9 || busy4) begin
      n_fail++;
      $display("[TB] FAIL idle_wait: busy9=%0b busy4=%0b, required both 0", busy9, busy4);
    end
  endtask

  // Start a pass, then compare every presented tap against the queue front.
  // A stall compares the held tap again; acceptance pops it.
  task automatic run_pass(input int sel, input int k, input int s, input int p_cfg, input int p_model,
                          input int bp, input logic exp_err, input string name);
    int nb, cyc, vcnt, exp_done;
    logic finished;
    logic o_tv, o_first, o_last, o_done, o_err;
    logic [44:0] o_img, o_oa;
    logic [4:0]  o_krn;
    logic [8:0]  o_act, o_tz;
    exp_t e;
    exp_q.delete();
    if (exp_err) exp_done = 2;
    else begin
      push_expected(sel ? 4 : 9, k, s, p_model, nb);
      exp_done = 2 + nb * k * k + (nb - 1) + (bp ? 3 : 0);
    end
    @(negedge clk);
    kernel_dim = KW'(k); stride_sel = s[0]; pad_en = p_cfg[0]; tap_ready = 1'b1; start = 1'b1;
    cyc = 0; vcnt = 0; finished = 1'b0;
    while (!finished && cyc < 500) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (sel == 1) begin
        o_tv = tv4; o_first = first4; o_last = last4; o_done = done4; o_err = err4;
        o_img = {25'b0, img4}; o_oa = {25'b0, out4}; o_krn = krn4;
        o_act = {5'b0, act4}; o_tz = {5'b0, tz4};
      end else begin
        o_tv = tv9; o_first = first9; o_last = last9; o_done = done9; o_err = err9;
        o_img = img9; o_oa = out9; o_krn = krn9; o_act = act9; o_tz = tz9;
      end
      tap_ready = (bp != 0 && vcnt >= 3 && vcnt < 6) ? 1'b0 : 1'b1;
      if (o_tv) begin
        vcnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL %s unexpected_tap: tap_valid=1 at cycle %0d, required 0", name, cyc);
        end else begin
          e = exp_q[0];
          n_checks += 6;
          if (o_img !== e.img) begin n_fail++; $display("[TB] FAIL %s img_addr cyc %0d: got %h required %h", name, cyc, o_img, e.img); end
          if (o_krn !== e.krn) begin n_fail++; $display("[TB] FAIL %s krn_addr cyc %0d: got %0d required %0d", name, cyc, o_krn, e.krn); end
          if (o_oa !== e.oa) begin n_fail++; $display("[TB] FAIL %s out_addr cyc %0d: got %h required %h", name, cyc, o_oa, e.oa); end
          if (o_act !== e.act) begin n_fail++; $display("[TB] FAIL %s active_units cyc %0d: got %h required %h", name, cyc, o_act, e.act); end
          if (o_tz !== e.tz) begin n_fail++; $display("[TB] FAIL %s tap_zero cyc %0d: got %h required %h", name, cyc, o_tz, e.tz); end
          if ({o_first, o_last} !== {e.first, e.last}) begin
            n_fail++;
            $display("[TB] FAIL %s first_last cyc %0d: got %b%b required %b%b", name, cyc, o_first, o_last, e.first, e.last);
          end
          if (tap_ready) void'(exp_q.pop_front());
        end
      end
      if (o_done) begin
        finished = 1'b1;
        n_checks += 3;
        if (cyc != exp_done) begin n_fail++; $display("[TB] FAIL %s done_cycle: got %0d required %0d", name, cyc, exp_done); end
        if (o_err !== exp_err) begin n_fail++; $display("[TB] FAIL %s error: got %b required %b", name, o_err, exp_err); end
        if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL %s taps_missing: got %0d left required 0", name, exp_q.size()); end
      end
    end
    if (!finished) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL %s timeout: no done within 500 cycles", name);
    end
    tap_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; kernel_dim = '0; stride_sel = 1'b0; pad_en = 1'b0; tap_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks += 3;
    if ({tv9, busy9, done9, err9, tv4, busy4, done4, err4} !== 8'b0) begin
      n_fail++; $display("[TB] FAIL reset_ctrl: got %b required 00000000", {tv9, busy9, done9, err9, tv4, busy4, done4, err4});
    end
    if ({img9, out9, krn9} !== '0) begin n_fail++; $display("[TB] FAIL reset_addr: got %h required 0", {img9, out9, krn9}); end
    if ({act9, tz9, first9, last9} !== '0) begin n_fail++; $display("[TB] FAIL reset_flags: got %h required 0", {act9, tz9, first9, last9}); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    run_pass(0, 3, 0, 0, 0, 0, 1'b0, "k3_s1");
    run_pass(0, 5, 0, 0, 0, 0, 1'b0, "k5_single");
    run_pass(0, 1, 1, 0, 0, 0, 1'b0, "k1_s2");
  endtask

  task automatic test_stride2();
    run_pass(0, 3, 1, 0, 0, 0, 1'b0, "k3_s2");
  endtask

  task automatic test_multi_batch();
    run_pass(1, 3, 0, 0, 0, 0, 1'b0, "n4_k3");
    run_pass(1, 2, 1, 0, 0, 0, 1'b0, "n4_k2_s2");
  endtask

  task automatic test_padding();
    run_pass(0, 3, 0, 1, PAD_BUILD, 0, 1'b0, "pad_k3");
  endtask

  task automatic test_back_to_back();
    run_pass(0, 3, 0, 0, 0, 1, 1'b0, "stall_k3");
    run_pass(0, 2, 0, 0, 0, 0, 1'b0, "b2b_k2");
  endtask

  task automatic test_error();
    run_pass(0, 0, 0, 0, 0, 0, 1'b1, "k0_err");
    repeat (2) @(negedge clk);
    n_checks++;
    if (err9 !== 1'b1 || busy9 !== 1'b0) begin
      n_fail++; $display("[TB] FAIL error_sticky: got err=%b busy=%b required err=1 busy=0", err9, busy9);
    end
    run_pass(0, 6, 0, 0, 0, 0, 1'b1, "k6_err");
    run_pass(0, 3, 0, 0, 0, 0, 1'b0, "err_clear");
  endtask

  task automatic test_reset_mid_pass();
    @(negedge clk);
    kernel_dim = 3'd3; stride_sel = 1'b0; pad_en = 1'b0; tap_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tv9 !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_pre: tap_valid=%b required 1", tv9); end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy9, tv9, busy4, tv4, err9} !== 5'b0) begin
      n_fail++; $display("[TB] FAIL midreset_idle: got %b required 00000", {busy9, tv9, busy4, tv4, err9});
    end
    @(negedge clk);
    reset = 1'b0;
    run_pass(0, 3, 0, 0, 0, 0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stride2();
    test_multi_batch();
    test_padding();
    test_back_to_back();
    test_error();
    test_reset_mid_pass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

endmodule
